// File: rtl/nat_str_pkg.sv
// Shared types for the native-to-AXI-Stream converter: framing states, FIFO entry layout, keep decode.
package nat_str_pkg;

   localparam int DATA_W = 32;
   localparam int KEEP_W = 4;

   typedef enum logic {
      IDLE     = 1'b0,
      IN_FRAME = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
      logic              user;
   } fifo_entry_t;

   // BC counts invalid trailing bytes on the EOF word; valid bytes are packed from lane 0.
   function automatic logic [KEEP_W-1:0] bc_to_keep(input logic [1:0] bc);
      logic [KEEP_W-1:0] keep;
      keep = 4'b1111;
      case (bc)
         2'd0:    keep = 4'b1111;
         2'd1:    keep = 4'b0111;
         2'd2:    keep = 4'b0011;
         2'd3:    keep = 4'b0001;
         default: keep = 4'b1111;
      endcase
      return keep;
   endfunction

endpackage

// File: rtl/nat_str_fifo.sv
// Synchronous FIFO of stream beats with registered fill count and a registered head-of-queue output.
module nat_str_fifo
   import nat_str_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_push,
   input  fifo_entry_t i_din,
   input  logic        i_pop,
   output fifo_entry_t o_dout,
   output logic        o_full,
   output logic        o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fifo_entry_t      r_mem [DEPTH];
   fifo_entry_t      r_dout;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_push;
   logic             w_pop;
   logic             w_bypass;
   logic [PTR_W-1:0] w_rd_ptr_next;
   logic [CNT_W-1:0] w_count_next;

   assign o_full   = (r_count == FULL_CNT);
   assign o_empty  = (r_count == '0);
   assign w_push   = i_push & ~o_full;
   assign w_pop    = i_pop & ~o_empty;
   assign w_rd_ptr_next = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
   // The incoming word becomes the new head when nothing older survives this edge.
   assign w_bypass = w_push & ((r_count == '0) | ((r_count == CNT_W'(1)) & w_pop));

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CNT_W'(1);
         2'b01:   w_count_next = r_count - CNT_W'(1);
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         r_rd_ptr <= w_rd_ptr_next;
         r_count  <= w_count_next;
         if (w_bypass) begin
            r_dout <= i_din;
         end else if (w_count_next != '0) begin
            r_dout <= r_mem[w_rd_ptr_next];
         end
      end
   end

   assign o_dout = r_dout;

endmodule

// File: rtl/nat_str_conv.sv
// Native packet interface to 32-bit AXI4-Stream master with framing checks and a buffering FIFO.
// Optional dropped-word counter enabled by defining NAT_STR_DROP_CNT_EN.
module nat_str_conv
   import nat_str_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Pkt_VALID_IN,
   input  logic [DATA_W-1:0] Pkt_DATA_IN,
   input  logic              Pkt_SOF_IN,
   input  logic              Pkt_EOF_IN,
   input  logic [1:0]        BC_IN,
   output logic              Pkt_RDY_OUT,
   output logic [DATA_W-1:0] STR_TDATA_OUT,
   output logic [KEEP_W-1:0] STR_TKEEP_OUT,
   output logic              STR_TLAST_OUT,
   output logic              STR_TUSER_OUT,
   output logic              STR_TVALID_OUT,
   input  logic              STR_TREADY_IN,
   output logic              ERR_OUT,
   output logic [15:0]       DROP_CNT_OUT
);

   state_t      r_state;
   state_t      w_state_next;
   logic        r_err;
   logic        w_accept;
   logic        w_push;
   logic        w_drop;
   logic        w_resof;
   logic        w_full;
   logic        w_empty;
   fifo_entry_t w_entry;
   fifo_entry_t w_head;

   assign w_accept = Pkt_VALID_IN & Pkt_RDY_OUT;
   assign w_entry  = '{data: Pkt_DATA_IN,
                       keep: Pkt_EOF_IN ? bc_to_keep(BC_IN) : {KEEP_W{1'b1}},
                       last: Pkt_EOF_IN,
                       user: Pkt_SOF_IN};

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_push       = 1'b0;
      w_drop       = 1'b0;
      w_resof      = 1'b0;
      if (w_accept) begin
         case (r_state)
            IDLE: begin
               if (Pkt_SOF_IN) begin
                  w_push = 1'b1;
                  if (!Pkt_EOF_IN) begin
                     w_state_next = IN_FRAME;
                  end
               end else begin
                  w_drop = 1'b1;
               end
            end
            IN_FRAME: begin
               // A restart abandons the open frame; the new word still goes out as a frame start.
               w_push  = 1'b1;
               w_resof = Pkt_SOF_IN;
               if (Pkt_EOF_IN) begin
                  w_state_next = IDLE;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_err <= 1'b0;
      end else if (w_drop | w_resof) begin
         r_err <= 1'b1;
      end
   end

`ifdef NAT_STR_DROP_CNT_EN
   logic [15:0] r_drop_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_drop_cnt <= '0;
      end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign DROP_CNT_OUT = r_drop_cnt;
`else
   assign DROP_CNT_OUT = '0;
`endif

   nat_str_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_push  (w_push),
      .i_din   (w_entry),
      .i_pop   (STR_TREADY_IN),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign Pkt_RDY_OUT    = ~w_full;
   assign STR_TVALID_OUT = ~w_empty;
   assign STR_TDATA_OUT  = w_head.data;
   assign STR_TKEEP_OUT  = w_head.keep;
   assign STR_TLAST_OUT  = w_head.last;
   assign STR_TUSER_OUT  = w_head.user;
   assign ERR_OUT        = r_err;

endmodule

// File: tb/tb_nat_str_conv.sv
// Bench for nat_str_conv: queue-based framing model checked every cycle, plus literal beat checks.
module tb_nat_str_conv;

   localparam int DEPTH = 8;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      logic        u;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vin = 1'b0;
   logic [31:0] din = '0;
   logic        sof = 1'b0;
   logic        eof = 1'b0;
   logic [1:0]  bc  = '0;
   logic        tready = 1'b0;
   logic        rdy;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tlast, tuser, tvalid, err;
   logic [15:0] drop_cnt;

   int n_cmp  = 0;
   int n_fail = 0;
   bit started = 1'b0;

   beat_t       q[$];
   beat_t       log_q[$];
   bit          m_in_frame = 1'b0;
   logic        m_err = 1'b0;
   logic [15:0] m_drop = '0;

   always #5 clk = ~clk;

   nat_str_conv #(.DEPTH(DEPTH)) dut (
      .CLK            (clk),
      .RST            (rst),
      .Pkt_VALID_IN   (vin),
      .Pkt_DATA_IN    (din),
      .Pkt_SOF_IN     (sof),
      .Pkt_EOF_IN     (eof),
      .BC_IN          (bc),
      .Pkt_RDY_OUT    (rdy),
      .STR_TDATA_OUT  (tdata),
      .STR_TKEEP_OUT  (tkeep),
      .STR_TLAST_OUT  (tlast),
      .STR_TUSER_OUT  (tuser),
      .STR_TVALID_OUT (tvalid),
      .STR_TREADY_IN  (tready),
      .ERR_OUT        (err),
      .DROP_CNT_OUT   (drop_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: framing rules applied to each accepted word; the queue is the FIFO contents.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_in_frame = 1'b0;
         m_err      = 1'b0;
         m_drop     = '0;
      end else begin
         bit acc;
         bit pop;
         acc = vin && (q.size() < DEPTH);
         pop = (q.size() != 0) && tready;
         if (pop) void'(q.pop_front());
         if (acc) begin
            if (!m_in_frame && !sof) begin
               m_err = 1'b1;
`ifdef NAT_STR_DROP_CNT_EN
               if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
`endif
            end else begin
               beat_t b;
               if (m_in_frame && sof) m_err = 1'b1;
               b.d = din;
               b.k = eof ? (4'hF >> bc) : 4'hF;
               b.l = eof;
               b.u = sof;
               q.push_back(b);
               m_in_frame = !eof;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("rdy", rdy, q.size() < DEPTH);
         chk("tvalid", tvalid, q.size() != 0);
         chk("err", err, m_err);
         chk("drop_cnt", drop_cnt, m_drop);
         if (q.size() != 0) begin
            chk("tdata", tdata, q[0].d);
            chk("tkeep", tkeep, q[0].k);
            chk("tlast", tlast, q[0].l);
            chk("tuser", tuser, q[0].u);
         end
         if (tvalid && tready && !rst) begin
            beat_t b;
            b.d = tdata; b.k = tkeep; b.l = tlast; b.u = tuser;
            log_q.push_back(b);
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] c);
      vin = 1'b1; din = d; sof = s; eof = e; bc = c;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (rdy) begin
            @(posedge clk);
            #1;
            vin = 1'b0;
            $display("word %h sof=%0b eof=%0b bc=%0d accepted at %0t", d, s, e, c, $time);
            return;
         end
      end
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: word %h not accepted, required acceptance within 200 cycles", d);
      vin = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
      chk("drain_empty", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      started = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_tvalid", tvalid, 1'b0);
      chk("reset_tdata", tdata, 32'h0);
      chk("reset_rdy", rdy, 1'b1);

      // Three-word frame, BC=2 on the last word
      tready = 1'b1;
      log_q.delete();
      @(posedge clk); #1;
      send(32'hA0000001, 1'b1, 1'b0, 2'd0);
      send(32'hA0000002, 1'b0, 1'b0, 2'd0);
      send(32'hA0000003, 1'b0, 1'b1, 2'd2);
      drain();
      chk("t1_beats", log_q.size(), 3);
      if (log_q.size() == 3) begin
         chk("t1_b0_user", log_q[0].u, 1'b1);
         chk("t1_b1_user", log_q[1].u, 1'b0);
         chk("t1_b2_data", log_q[2].d, 32'hA0000003);
         chk("t1_b2_keep", log_q[2].k, 4'b0011);
         chk("t1_b2_last", log_q[2].l, 1'b1);
      end
      chk("t1_err", err, 1'b0);

      // Single-word frame
      log_q.delete();
      send(32'h00000055, 1'b1, 1'b1, 2'd3);
      drain();
      chk("t2_beats", log_q.size(), 1);
      if (log_q.size() == 1) begin
         chk("t2_keep", log_q[0].k, 4'b0001);
         chk("t2_last", log_q[0].l, 1'b1);
         chk("t2_user", log_q[0].u, 1'b1);
      end

      // Back-pressure: 10-word frame against a stalled sink
      log_q.delete();
      tready = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++)
               send(32'hB0000000 + 32'(i), i == 0, i == 9, 2'd0);
         end
         begin
            repeat (14) @(posedge clk);
            #1;
            chk("t3_full_rdy", rdy, 1'b0);
            chk("t3_hold_tdata", tdata, 32'hB0000000);
            tready = 1'b1;
         end
      join
      drain();
      chk("t3_beats", log_q.size(), 10);
      for (int i = 0; i < 10 && i < log_q.size(); i++)
         chk("t3_order", log_q[i].d, 32'hB0000000 + 32'(i));

      // SOF on word 3 of an open frame
      log_q.delete();
      send(32'hF0000000, 1'b1, 1'b0, 2'd0);
      send(32'hF0000001, 1'b0, 1'b0, 2'd0);
      send(32'hF0000002, 1'b1, 1'b0, 2'd0);
      send(32'hF0000003, 1'b0, 1'b1, 2'd0);
      drain();
      chk("t5_beats", log_q.size(), 4);
      if (log_q.size() == 4) begin
         chk("t5_prior_last", log_q[1].l, 1'b0);
         chk("t5_restart_user", log_q[2].u, 1'b1);
         chk("t5_end_keep", log_q[3].k, 4'b1111);
      end
      chk("t5_err", err, 1'b1);

      // Reset mid-frame with five words buffered
      tready = 1'b0;
      send(32'hC0000000, 1'b1, 1'b0, 2'd0);
      for (int i = 1; i < 5; i++) send(32'hC0000000 + 32'(i), 1'b0, 1'b0, 2'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_tvalid", tvalid, 1'b0);
      chk("t6_rdy", rdy, 1'b1);
      chk("t6_err", err, 1'b0);
      log_q.delete();
      tready = 1'b1;
      @(posedge clk); #1;
      send(32'hD0000000, 1'b1, 1'b0, 2'd0);
      send(32'hD0000001, 1'b0, 1'b1, 2'd1);
      drain();
      chk("t6_beats", log_q.size(), 2);
      if (log_q.size() == 2) begin
         chk("t6_b0_data", log_q[0].d, 32'hD0000000);
         chk("t6_b0_user", log_q[0].u, 1'b1);
         chk("t6_b1_keep", log_q[1].k, 4'b0111);
      end

      // Out-of-frame words while idle
      log_q.delete();
      send(32'hE0000001, 1'b0, 1'b0, 2'd0);
      send(32'hE0000002, 1'b0, 1'b0, 2'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_beats", log_q.size(), 0);
      chk("t4_err", err, 1'b1);
`ifdef NAT_STR_DROP_CNT_EN
      chk("t4_drop", drop_cnt, 16'd2);
`else
      chk("t4_drop", drop_cnt, 16'd0);
`endif

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
